// File: rtl/apb_master.sv
// ============================================================================
// apb_master : valid/ready command to single APB transfer, held response.
// Optional abort on ACCESS timeout when APB_MASTER_TIMEOUT_EN is defined.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module apb_master #(
  parameter int PADDR_WIDTH    = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [PADDR_WIDTH-1:0]  paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("apb_master: DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [PADDR_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             rsp_err_q;
  logic             tmo_hit;

  // Counter holds the number of wait cycles already spent in ACCESS.
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q  <= ST_SETUP;
            psel_q   <= 1'b1;
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            if (cmd_write) begin
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_strb;
            end else begin
              pstrb_q  <= '0;
            end
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          // pready takes priority over a timeout landing on the same cycle.
          if (pready) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmo_hit) begin
            state_q     <= ST_RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + TMO_W'(1);
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by presetn so the command channel stays closed while in reset.
  assign cmd_ready = (state_q == ST_IDLE) && presetn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// tb_apb_master : directed self-checking bench for apb_master.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;

  logic [31:0] prdata_drv;
  logic        use_mem;
  logic [31:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  apb_master #(
    .PADDR_WIDTH    (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  // Simple byte-strobed completer memory, word-indexed by paddr[5:2].
  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) begin
      for (int b = 0; b < 4; b++) begin
        if (pstrb[b]) mem[paddr[5:2]][b*8 +: 8] <= pwdata[b*8 +: 8];
      end
    end
  end

  assign prdata = use_mem ? mem[paddr[5:2]] : prdata_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic run_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic er);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_strb  = st;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick;
      n++;
    end
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick;
      n++;
    end
    check("xfer_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n_acc;
    logic [15:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    logic        b2b_wr   [3];
    int          idx;
    int          n_rise;
    int          n_rsp;
    int          last_rise;
    logic        psel_prev;
    logic        accept;

    presetn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strb   = '0;
    rsp_ready  = 1'b0;
    pready     = 1'b1;
    prdata_drv = '0;
    use_mem    = 1'b0;

    // Reset state
    tick; tick; tick;
    check("rst_psel", {31'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    presetn = 1'b1;
    #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Write, no wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010;
    cmd_wdata = 32'hA5A5_1234; cmd_strb = 4'hF; pready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check("wr_setup_psel", {31'd0, psel}, 32'd1);
    check("wr_setup_penable", {31'd0, penable}, 32'd0);
    check("wr_setup_pwrite", {31'd0, pwrite}, 32'd1);
    check("wr_setup_paddr", {16'd0, paddr}, 32'h0010);
    check("wr_setup_pwdata", pwdata, 32'hA5A5_1234);
    check("wr_setup_pstrb", {28'd0, pstrb}, 32'hF);
    tick;
    check("wr_access_psel", {31'd0, psel}, 32'd1);
    check("wr_access_penable", {31'd0, penable}, 32'd1);
    check("wr_access_pwdata", pwdata, 32'hA5A5_1234);
    check("wr_access_pstrb", {28'd0, pstrb}, 32'hF);
    tick;
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_rsp_psel", {31'd0, psel}, 32'd0);
    check("wr_rsp_penable", {31'd0, penable}, 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("wr_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Read, 3 wait states
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0004;
    pready = 1'b0; prdata_drv = 32'hDEAD_BEEF;
    tick;
    cmd_valid = 1'b0;
    check("rd_setup_pwrite", {31'd0, pwrite}, 32'd0);
    check("rd_setup_pstrb", {28'd0, pstrb}, 32'd0);
    n_acc = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      if (psel && penable) begin
        n_acc++;
        check("rd_access_pstrb", {28'd0, pstrb}, 32'd0);
        pready = (n_acc == 4);
      end
      tick;
    end
    check("rd_ws_access_cycles", n_acc, 32'd4);
    check("rd_ws_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_ws_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_ws_psel_after", {31'd0, psel}, 32'd0);

    // Response backpressure with a new command waiting
    pready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h000C;
    cmd_wdata = 32'h1111_2222; cmd_strb = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_psel", {31'd0, psel}, 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("bp_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_idle_psel", {31'd0, psel}, 32'd0);
    tick;
    cmd_valid = 1'b0;
    check("bp_setup_psel", {31'd0, psel}, 32'd1);
    check("bp_setup_penable", {31'd0, penable}, 32'd0);
    check("bp_setup_paddr", {16'd0, paddr}, 32'h000C);
    check("bp_setup_pstrb", {28'd0, pstrb}, 32'h3);
    tick;
    tick;
    check("bp_wr_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // Reset mid-ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0008; pready = 1'b0;
    tick;
    cmd_valid = 1'b0;
    tick;
    check("mid_access_psel", {31'd0, psel}, 32'd1);
    check("mid_access_penable", {31'd0, penable}, 32'd1);
    presetn = 1'b0;
    #1;
    check("mid_rst_psel", {31'd0, psel}, 32'd0);
    check("mid_rst_penable", {31'd0, penable}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick; tick;
    presetn = 1'b1;
    pready = 1'b1;
    prdata_drv = 32'h0BAD_F00D;
    run_xfer(1'b0, 16'h0008, 32'd0, 4'h0, rd, er);
    check("post_rst_rd_rdata", rd, 32'h0BAD_F00D);
    check("post_rst_rd_err", {31'd0, er}, 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout with pready stuck low
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0004;
    pready = 1'b0; prdata_drv = 32'h0000_1234;
    tick;
    cmd_valid = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      if (psel && penable) n_acc++;
      tick;
    end
    check("tmo_access_cycles", n_acc, 32'd4);
    check("tmo_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("tmo_rsp_rdata", rsp_rdata, 32'd0);
    check("tmo_psel_after", {31'd0, psel}, 32'd0);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;

    // pready on the final allowed cycle completes normally
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0004; pready = 1'b0;
    tick;
    cmd_valid = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      if (psel && penable) begin
        n_acc++;
        pready = (n_acc == 4);
      end
      tick;
    end
    check("tmo_edge_access_cycles", n_acc, 32'd4);
    check("tmo_edge_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("tmo_edge_rsp_rdata", rsp_rdata, 32'h0000_1234);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    pready = 1'b1;
`endif

    // Back-to-back through the completer memory
    b2b_wr[0] = 1'b1; b2b_addr[0] = 16'h0000; b2b_data[0] = 32'h1357_9BDF;
    b2b_wr[1] = 1'b0; b2b_addr[1] = 16'h0000; b2b_data[1] = 32'h0;
    b2b_wr[2] = 1'b1; b2b_addr[2] = 16'h0020; b2b_data[2] = 32'h2468_ACE0;
    use_mem = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    idx = 0;
    cmd_valid = 1'b1; cmd_write = b2b_wr[0]; cmd_addr = b2b_addr[0];
    cmd_wdata = b2b_data[0]; cmd_strb = 4'hF;
    n_rise = 0; n_rsp = 0; last_rise = 0; psel_prev = 1'b0;
    for (int cyc = 0; cyc < 40 && n_rsp < 3; cyc++) begin
      if (psel && !psel_prev) begin
        if (n_rise > 0) check("b2b_psel_gap", cyc - last_rise, 32'd4);
        if (n_rise < 3) check("b2b_paddr", {16'd0, paddr}, {16'd0, b2b_addr[n_rise]});
        last_rise = cyc;
        n_rise++;
      end
      psel_prev = psel;
      if (rsp_valid) begin
        if (n_rsp == 1) check("b2b_read_back", rsp_rdata, 32'h1357_9BDF);
        n_rsp++;
      end
      accept = cmd_valid && cmd_ready;
      tick;
      if (accept) begin
        idx++;
        if (idx < 3) begin
          cmd_write = b2b_wr[idx];
          cmd_addr  = b2b_addr[idx];
          cmd_wdata = b2b_data[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    check("b2b_psel_rises", n_rise, 32'd3);
    check("b2b_responses", n_rsp, 32'd3);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
